// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch stage bus: imem port, execute redirect inputs, decode outputs
interface fetch_pc_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             imem_ready;
  logic             ex_valid;
  logic [2:0]       pc_sel;
  logic [31:0]      alu_target;
  logic [31:0]      jal_target;
  logic [31:0]      inst_in;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic [31:0]      inst_out;
  logic [31:0]      pc_out;
  logic             inst_valid;
  logic             misalign;
  logic             illegal;
  logic [CNT_W-1:0] redirect_cnt;

  // The fetch unit itself
  modport master (
    input  stall, imem_ready, ex_valid, pc_sel, alu_target, jal_target, inst_in,
    output imem_addr, imem_req, inst_out, pc_out, inst_valid, misalign, illegal,
           redirect_cnt
  );

  // Surrounding pipeline and instruction memory
  modport slave (
    output stall, imem_ready, ex_valid, pc_sel, alu_target, jal_target, inst_in,
    input  imem_addr, imem_req, inst_out, pc_out, inst_valid, misalign, illegal,
           redirect_cnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - RV32I fetch stage: PC register, imem request, redirect squash
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h4000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h4000_0100,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_unit_if.master  bus
);

  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             req_valid;
  logic [31:0]      inst_q;
  logic [31:0]      pc_q;
  logic             valid_q;
  logic             misalign_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic             advance;
  logic             redirect;
  logic             is_trap;
  logic [31:0]      raw_target;
  logic             target_misaligned;
  logic [31:0]      target;

  // Whole unit freezes unless downstream accepts and imem data is valid
  assign advance  = !bus.stall && bus.imem_ready;
  assign is_trap  = (bus.pc_sel == 3'd0);
  assign redirect = bus.ex_valid &&
                    (is_trap || bus.pc_sel == 3'd3 || bus.pc_sel == 3'd4);

  // Redirect target select; JALR-style targets drop bit0 before alignment check
  always_comb begin
    raw_target = TRAP_VECTOR;
    case (bus.pc_sel)
      3'd3:    raw_target = {bus.alu_target[31:1], 1'b0};
      3'd4:    raw_target = bus.jal_target;
      default: raw_target = TRAP_VECTOR;
    endcase
  end

  assign target_misaligned = (raw_target[1:0] != 2'b00);
  assign target            = {raw_target[31:2], 2'b00};

  // PC, in-flight request tracking and decode-stage output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc   <= RESET_VECTOR;
      req_pc     <= 32'h0;
      req_valid  <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else if (advance) begin
      misalign_q <= redirect && target_misaligned;
      illegal_q  <= redirect && is_trap;
      if (redirect) begin
        // Squash the fetch in flight; the stale imem data is dropped next edge
        fetch_pc  <= target;
        req_valid <= 1'b0;
        inst_q    <= NOP_INST;
        valid_q   <= 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        fetch_pc  <= fetch_pc + 32'd4;
        req_pc    <= fetch_pc;
        req_valid <= 1'b1;
        inst_q    <= req_valid ? bus.inst_in : NOP_INST;
        pc_q      <= req_pc;
        valid_q   <= req_valid;
      end
    end else begin
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end
  end

  assign bus.imem_addr    = fetch_pc;
  assign bus.imem_req     = rst && !bus.stall;
  assign bus.inst_out     = inst_q;
  assign bus.pc_out       = pc_q;
  assign bus.inst_valid   = valid_q;
  assign bus.misalign     = misalign_q;
  assign bus.illegal      = illegal_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asrt  = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.CNT_W(16)) bus ();
  fetch_pc_unit_if #(.CNT_W(2))  bus2 ();

  fetch_pc_unit #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_pc_unit #(.CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // Synchronous-read memory: word at address a reads as {a[31:2], 2'b11}
  logic [31:0] mem_q = 32'h0;
  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_ready) mem_q <= {bus.imem_addr[31:2], 2'b11};
  end
  assign bus.inst_in = mem_q;
  assign bus2.inst_in = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    asrt++; if (bus.inst_out !== 32'h0000_0013) begin fails++; $display("FAIL rst_inst got %h exp 00000013", bus.inst_out); end
    asrt++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", bus.inst_valid); end
    asrt++; if (bus.pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", bus.pc_out); end
    asrt++; if (bus.imem_addr !== 32'h4000_0000) begin fails++; $display("FAIL rst_addr got %h exp 40000000", bus.imem_addr); end
    asrt++; if (bus.redirect_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", bus.redirect_cnt); end
    asrt++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    asrt++; if ({bus.misalign, bus.illegal} !== 2'b00) begin fails++; $display("FAIL rst_pulses got %b exp 00", {bus.misalign, bus.illegal}); end
    rst = 1'b1;
    #1;
    asrt++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL req_after_rst got %b exp 1", bus.imem_req); end
  endtask

  task automatic test_sequential();
    tick();
    asrt++; if (bus.imem_addr !== 32'h4000_0004) begin fails++; $display("FAIL seq_addr1 got %h exp 40000004", bus.imem_addr); end
    asrt++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL seq_valid1 got %b exp 0", bus.inst_valid); end
    tick();
    asrt++; if (bus.imem_addr !== 32'h4000_0008) begin fails++; $display("FAIL seq_addr2 got %h exp 40000008", bus.imem_addr); end
    asrt++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4000_0000 || bus.inst_out !== 32'h4000_0003) begin
      fails++; $display("FAIL seq_first got v=%b pc=%h inst=%h exp v=1 pc=40000000 inst=40000003", bus.inst_valid, bus.pc_out, bus.inst_out); end
    tick();
    asrt++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4000_0004 || bus.inst_out !== 32'h4000_0007) begin
      fails++; $display("FAIL seq_second got v=%b pc=%h inst=%h exp v=1 pc=40000004 inst=40000007", bus.inst_valid, bus.pc_out, bus.inst_out); end
  endtask

  task automatic test_branch();
    bus.ex_valid = 1'b1; bus.pc_sel = 3'd3; bus.alu_target = 32'h4000_0201;
    tick();
    bus.ex_valid = 1'b0; bus.pc_sel = 3'd2;
    asrt++; if (bus.imem_addr !== 32'h4000_0200) begin fails++; $display("FAIL br_addr got %h exp 40000200", bus.imem_addr); end
    asrt++; if (bus.misalign !== 1'b0) begin fails++; $display("FAIL br_misalign got %b exp 0", bus.misalign); end
    asrt++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0000_0013) begin fails++; $display("FAIL br_bubble1 got v=%b inst=%h exp v=0 inst=00000013", bus.inst_valid, bus.inst_out); end
    asrt++; if (bus.redirect_cnt !== 16'd1) begin fails++; $display("FAIL br_cnt got %0d exp 1", bus.redirect_cnt); end
    tick();
    asrt++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0000_0013) begin fails++; $display("FAIL br_bubble2 got v=%b inst=%h exp v=0 inst=00000013", bus.inst_valid, bus.inst_out); end
    tick();
    asrt++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4000_0200 || bus.inst_out !== 32'h4000_0203) begin
      fails++; $display("FAIL br_target got v=%b pc=%h inst=%h exp v=1 pc=40000200 inst=40000203", bus.inst_valid, bus.pc_out, bus.inst_out); end
  endtask

  task automatic test_jal_trap();
    bus.ex_valid = 1'b1; bus.pc_sel = 3'd4; bus.jal_target = 32'h4000_0102;
    tick();
    asrt++; if (bus.misalign !== 1'b1 || bus.imem_addr !== 32'h4000_0100) begin fails++; $display("FAIL jal got mis=%b addr=%h exp mis=1 addr=40000100", bus.misalign, bus.imem_addr); end
    asrt++; if (bus.redirect_cnt !== 16'd2) begin fails++; $display("FAIL jal_cnt got %0d exp 2", bus.redirect_cnt); end
    bus.pc_sel = 3'd0;
    tick();
    asrt++; if (bus.illegal !== 1'b1 || bus.misalign !== 1'b0 || bus.imem_addr !== 32'h4000_0100) begin
      fails++; $display("FAIL trap got ill=%b mis=%b addr=%h exp ill=1 mis=0 addr=40000100", bus.illegal, bus.misalign, bus.imem_addr); end
    bus.ex_valid = 1'b0;
    tick();
    asrt++; if (bus.illegal !== 1'b0 || bus.imem_addr !== 32'h4000_0104 || bus.redirect_cnt !== 16'd3) begin
      fails++; $display("FAIL no_trap got ill=%b addr=%h cnt=%0d exp ill=0 addr=40000104 cnt=3", bus.illegal, bus.imem_addr, bus.redirect_cnt); end
    bus.pc_sel = 3'd2;
    tick();
    asrt++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4000_0100 || bus.imem_addr !== 32'h4000_0108) begin
      fails++; $display("FAIL trap_flow got v=%b pc=%h addr=%h exp v=1 pc=40000100 addr=40000108", bus.inst_valid, bus.pc_out, bus.imem_addr); end
  endtask

  task automatic test_stall_redirect();
    bus.stall = 1'b1; bus.ex_valid = 1'b1; bus.pc_sel = 3'd3; bus.alu_target = 32'h4000_0300;
    #1;
    asrt++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got %b exp 0", bus.imem_req); end
    for (int i = 0; i < 3; i++) tick();
    asrt++; if (bus.imem_addr !== 32'h4000_0108 || bus.pc_out !== 32'h4000_0100 || bus.inst_valid !== 1'b1) begin
      fails++; $display("FAIL stall_hold got addr=%h pc=%h v=%b exp addr=40000108 pc=40000100 v=1", bus.imem_addr, bus.pc_out, bus.inst_valid); end
    asrt++; if (bus.redirect_cnt !== 16'd3 || bus.illegal !== 1'b0) begin fails++; $display("FAIL stall_cnt got cnt=%0d ill=%b exp cnt=3 ill=0", bus.redirect_cnt, bus.illegal); end
    bus.stall = 1'b0;
    tick();
    bus.ex_valid = 1'b0; bus.pc_sel = 3'd2;
    asrt++; if (bus.imem_addr !== 32'h4000_0300 || bus.redirect_cnt !== 16'd4 || bus.inst_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release got addr=%h cnt=%0d v=%b exp addr=40000300 cnt=4 v=0", bus.imem_addr, bus.redirect_cnt, bus.inst_valid); end
    tick();
    asrt++; if (bus.redirect_cnt !== 16'd4 || bus.imem_addr !== 32'h4000_0304) begin fails++; $display("FAIL stall_single got cnt=%0d addr=%h exp cnt=4 addr=40000304", bus.redirect_cnt, bus.imem_addr); end
  endtask

  task automatic test_imem_wait();
    tick();
    asrt++; if (bus.pc_out !== 32'h4000_0300 || bus.inst_out !== 32'h4000_0303) begin fails++; $display("FAIL wait_pre got pc=%h inst=%h exp pc=40000300 inst=40000303", bus.pc_out, bus.inst_out); end
    bus.imem_ready = 1'b0;
    tick();
    tick();
    asrt++; if (bus.imem_addr !== 32'h4000_0308 || bus.pc_out !== 32'h4000_0300 || bus.inst_out !== 32'h4000_0303) begin
      fails++; $display("FAIL wait_hold got addr=%h pc=%h inst=%h exp addr=40000308 pc=40000300 inst=40000303", bus.imem_addr, bus.pc_out, bus.inst_out); end
    bus.imem_ready = 1'b1;
    tick();
    asrt++; if (bus.pc_out !== 32'h4000_0304 || bus.inst_out !== 32'h4000_0307 || bus.inst_valid !== 1'b1) begin
      fails++; $display("FAIL wait_resume1 got pc=%h inst=%h v=%b exp pc=40000304 inst=40000307 v=1", bus.pc_out, bus.inst_out, bus.inst_valid); end
    tick();
    asrt++; if (bus.pc_out !== 32'h4000_0308 || bus.inst_out !== 32'h4000_030B) begin fails++; $display("FAIL wait_resume2 got pc=%h inst=%h exp pc=40000308 inst=4000030b", bus.pc_out, bus.inst_out); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    bus2.ex_valid = 1'b1; bus2.pc_sel = 3'd4; bus2.jal_target = 32'h4000_0040;
    for (int i = 0; i < 4; i++) begin
      tick();
      asrt++; if (bus2.redirect_cnt !== exp_cnt[i]) begin fails++; $display("FAIL sat_cnt%0d got %0d exp %0d", i, bus2.redirect_cnt, exp_cnt[i]); end
    end
    bus2.ex_valid = 1'b0;
  endtask

  task automatic test_midstream_reset();
    bus.ex_valid = 1'b1; bus.pc_sel = 3'd3; bus.alu_target = 32'h4000_0500;
    rst = 1'b0;
    tick();
    asrt++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h4000_0000 || bus.redirect_cnt !== 16'd0) begin
      fails++; $display("FAIL mid_rst got v=%b addr=%h cnt=%0d exp v=0 addr=40000000 cnt=0", bus.inst_valid, bus.imem_addr, bus.redirect_cnt); end
    asrt++; if (bus2.redirect_cnt !== 2'd0 || bus.inst_out !== 32'h0000_0013) begin
      fails++; $display("FAIL mid_rst2 got cnt2=%0d inst=%h exp cnt2=0 inst=00000013", bus2.redirect_cnt, bus.inst_out); end
    bus.ex_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    asrt++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4000_0000) begin fails++; $display("FAIL post_rst got v=%b pc=%h exp v=1 pc=40000000", bus.inst_valid, bus.pc_out); end
  endtask

  initial begin
    bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.ex_valid = 1'b0; bus.pc_sel = 3'd2;
    bus.alu_target = 32'h0; bus.jal_target = 32'h0;
    bus2.stall = 1'b0; bus2.imem_ready = 1'b1; bus2.ex_valid = 1'b0; bus2.pc_sel = 3'd2;
    bus2.alu_target = 32'h0; bus2.jal_target = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_jal_trap();
    test_stall_redirect();
    test_imem_wait();
    test_saturation();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the three-stage RV32I pipeline. It sits directly upstream of the decode/control stage.
- Owns the fetch PC register and drives the synchronous-read instruction memory.
- Registers the returned instruction together with its PC for the decode/execute stage.
- Consumes the execute stage's PC-select code and branch/jump targets, squashes wrong-path fetches, and counts redirects.

Parameters:
RESET_VECTOR, 32'h4000_0000, first fetch address after reset (BIOS region)
TRAP_VECTOR, 32'h4000_0100, fetch address on an illegal-instruction redirect
NOP_INST, 32'h0000_0013, instruction word emitted on bubbles (addi x0,x0,0)
CNT_W, 16, width of redirect counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
stall  input  1  downstream hold; 1 freezes the whole unit
imem_ready  input  1  imem data valid this cycle; 0 freezes the whole unit
ex_valid  input  1  execute-stage instruction is valid; qualifies pc_sel
pc_sel  input  3  0=illegal/trap, 2=PC+4, 3=ALU target (branch taken/JALR), 4=JAL target, 1/5/6/7=treated as 2
alu_target  input  32  branch/JALR target from ALU
jal_target  input  32  JAL target
inst_in  input  32  imem read data for the address issued the previous advancing cycle
imem_addr  output  32  fetch address, equal to fetch_pc register
imem_req  output  1  1 when rst=1 and stall=0
inst_out  output  32  instruction to decode/control stage
pc_out  output  32  PC of inst_out
inst_valid  output  1  inst_out is a valid, non-squashed instruction
misalign  output  1  one-cycle pulse: redirect target had bits[1:0]!=0
illegal  output  1  one-cycle pulse: trap redirect taken
redirect_cnt  output  CNT_W  saturating count of redirects

Behaviour:
- Reset (rst=0 at posedge) sets: fetch_pc=RESET_VECTOR; req_pc=0; req_valid=0; inst_out=NOP_INST; pc_out=0; inst_valid=0; misalign=0; illegal=0; redirect_cnt=0.
- Reset takes priority over every other input. Reset asserted mid-operation discards all in-flight state.
- Internal state: fetch_pc (address being issued), req_pc/req_valid (address issued last cycle, whose data is on inst_in).
- advance = stall==0 && imem_ready==1. With advance=0 all registers hold and misalign/illegal drive 0.
- Redirect is sampled only on advancing edges. The execute stage holds pc_sel/ex_valid while stalled.
- redirect = ex_valid && pc_sel in {0,3,4}.
- Target selection:
  - pc_sel=3: target = alu_target with bit0 cleared.
  - pc_sel=4: target = jal_target.
  - pc_sel=0: target = TRAP_VECTOR, and illegal pulses.
- If target[1:0]!=0 after selection: misalign pulses and target[1:0] is forced to 0.
- Advancing edge with redirect:
  - fetch_pc <= target; req_valid <= 0 (squash in-flight fetch).
  - inst_out <= NOP_INST; inst_valid <= 0; pc_out holds.
  - redirect_cnt increments, saturating at all-ones.
- Advancing edge without redirect:
  - fetch_pc <= fetch_pc+4 (wraps modulo 2^32).
  - req_pc <= fetch_pc; req_valid <= 1.
  - inst_out <= inst_in; pc_out <= req_pc; inst_valid <= req_valid.
  - When req_valid=0, inst_out <= NOP_INST instead of inst_in.
- Redirect penalty is exactly two bubbles: the target's instruction appears with inst_valid=1 after the second advancing edge following the redirect edge.
- After reset release, the first valid instruction (pc_out=RESET_VECTOR) appears after the second advancing edge.
- Stall concurrent with redirect: the redirect is deferred until the first advancing edge. No double count.
- redirect_cnt at saturation stays saturated.

Test Plan:
- Reset release, stall=0, imem_ready=1, ex_valid=0, sequential memory: imem_addr 4000_0000, 4000_0004, 4000_0008 on successive cycles; inst_valid first 1 after edge 2 with pc_out=4000_0000, then pc_out=4000_0004.
- Sequential fetch with pc_sel=3, ex_valid=1, alu_target=4000_0201 for one cycle: next imem_addr=4000_0200, misalign=0, two cycles inst_valid=0 with inst_out=0000_0013, then pc_out=4000_0200 valid; redirect_cnt=1.
- pc_sel=4, jal_target=4000_0102: misalign pulses 1 cycle, imem_addr=4000_0100. pc_sel=0 with ex_valid=1: illegal pulses, imem_addr=4000_0100. pc_sel=0 with ex_valid=0: no redirect.
- stall=1 for 3 cycles concurrent with a pc_sel=3 redirect: all outputs frozen, imem_req=0, redirect_cnt unchanged; on release a single redirect occurs, redirect_cnt +1.
- imem_ready=0 for 2 cycles mid-stream: inst_out/pc_out/fetch_pc hold; on resume no instruction is skipped or duplicated.
- CNT_W=2, four consecutive redirects: redirect_cnt 1,2,3,3. Assert rst=0 mid-stream: after the edge inst_valid=0, imem_addr=4000_0000, redirect_cnt=0.
